// File: rtl/retire_ctrl.sv
// retire_ctrl: commit-stage sequencer between the ROB head and the
// architectural state (arch map, free list, D-cache store port).
// Decides per-cycle retirement, serialises stores through a
// req/grant/done handshake, and handles rollback drain and halt.
module retire_ctrl #(
    parameter int WIDTH        = 2,
    parameter int PRF_IDX_W    = 6,
    parameter int RF_IDX_W     = 5,
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          ready_to_retire,
    input  logic                      rob_rollback,
    input  logic [WIDTH-1:0]          head_wr_mem,
    input  logic [WIDTH-1:0]          head_halt,
    input  logic [WIDTH*RF_IDX_W-1:0] head_dest,
    input  logic [WIDTH*PRF_IDX_W-1:0] head_tag,
    input  logic [WIDTH*PRF_IDX_W-1:0] head_tag_old,
    input  logic [WIDTH*XLEN-1:0]     head_mem_addr,
    input  logic [WIDTH*XLEN-1:0]     head_mem_data,
    input  logic [WIDTH*2-1:0]        head_mem_size,
    input  logic                      mem_grant,
    input  logic                      mem_done,
    output logic [WIDTH-1:0]          retire_en,
    output logic [WIDTH-1:0]          free_en,
    output logic [WIDTH*PRF_IDX_W-1:0] free_tag,
    output logic [WIDTH-1:0]          arch_wr_en,
    output logic [WIDTH*RF_IDX_W-1:0] arch_dest,
    output logic [WIDTH*PRF_IDX_W-1:0] arch_tag,
    output logic                      mem_req,
    output logic [XLEN-1:0]           mem_addr,
    output logic [XLEN-1:0]           mem_data,
    output logic [1:0]                mem_size,
    output logic                      halted,
    output logic [31:0]               retired_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        ST_REQ,
        ST_WAIT,
        ST_COMMIT,
        FLUSH,
        HALTED
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       flush_cnt;
    logic [CNT_W-1:0] retire_count;

    logic slot0_ready;
    logic slot0_store;
    logic slot0_halt;

    assign slot0_ready = ready_to_retire[0];
    assign slot0_store = head_wr_mem[0];
    assign slot0_halt  = head_halt[0];

    // Only slot 0 can issue a store, so the other slots' memory fields are never consumed.
    logic unused_mem_fields;
    assign unused_mem_fields = ^{head_mem_addr[WIDTH*XLEN-1:XLEN],
                                 head_mem_data[WIDTH*XLEN-1:XLEN],
                                 head_mem_size[WIDTH*2-1:2]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; rollback only matters while sitting in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (slot0_ready) begin
                    if (slot0_store) begin
                        next_state = ST_REQ;
                    end else if (slot0_halt) begin
                        next_state = HALTED;
                    end else if (rob_rollback) begin
                        next_state = FLUSH;
                    end
                end
            end
            ST_REQ: begin
                if (mem_grant) begin
                    next_state = mem_done ? ST_COMMIT : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                next_state = IDLE;
            end
            FLUSH: begin
                if (flush_cnt <= 4'd1) begin
                    next_state = IDLE;
                end
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode: per-slot retire pulses and the store request.
    always_comb begin
        logic chain;
        retire_en = '0;
        mem_req   = 1'b0;
        chain     = 1'b0;
        case (state)
            IDLE: begin
                if (slot0_ready && !slot0_store) begin
                    retire_en[0] = 1'b1;
                    chain        = !slot0_halt && !rob_rollback;
                    for (int w = 1; w < WIDTH; w++) begin
                        chain = chain && ready_to_retire[w] && !head_wr_mem[w] && !head_halt[w];
                        retire_en[w] = chain;
                    end
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
            end
            ST_COMMIT: begin
                retire_en[0] = 1'b1;
            end
            default: begin
                retire_en = '0;
            end
        endcase
    end

    // Architectural map and free-list updates for every retiring slot with a real destination.
    generate
        for (genvar w = 0; w < WIDTH; w++) begin : g_slot
            logic has_dest;
            assign has_dest = head_dest[w*RF_IDX_W +: RF_IDX_W] != '0;
            assign free_en[w]    = retire_en[w] && has_dest;
            assign arch_wr_en[w] = retire_en[w] && has_dest;
            assign free_tag[w*PRF_IDX_W +: PRF_IDX_W]  = head_tag_old[w*PRF_IDX_W +: PRF_IDX_W];
            assign arch_dest[w*RF_IDX_W +: RF_IDX_W]   = head_dest[w*RF_IDX_W +: RF_IDX_W];
            assign arch_tag[w*PRF_IDX_W +: PRF_IDX_W]  = head_tag[w*PRF_IDX_W +: PRF_IDX_W];
        end
    endgenerate

    // Post-rollback drain counter: loaded on the rollback commit, counts down while flushing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= 4'd0;
        end else if (state == IDLE && next_state == FLUSH) begin
            flush_cnt <= 4'(FLUSH_CYCLES);
        end else if (state == FLUSH && flush_cnt != 4'd0) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    // Capture the slot-0 store so the D-cache sees stable fields for the whole handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_data <= '0;
            mem_size <= 2'b00;
        end else if (state == IDLE && next_state == ST_REQ) begin
            mem_addr <= head_mem_addr[XLEN-1:0];
            mem_data <= head_mem_data[XLEN-1:0];
            mem_size <= head_mem_size[1:0];
        end
    end

    // Sticky halt flag, set when the halting instruction commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (state == IDLE && next_state == HALTED) begin
            halted <= 1'b1;
        end
    end

    // Number of slots retiring this cycle.
    always_comb begin
        retire_count = '0;
        for (int w = 0; w < WIDTH; w++) begin
            retire_count = retire_count + CNT_W'(retire_en[w]);
        end
    end

    // Running total of retired instructions, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt <= 32'd0;
        end else begin
            retired_cnt <= retired_cnt + 32'(retire_count);
        end
    end

endmodule

// File: tb/tb_retire_ctrl.sv
// Self-checking bench for retire_ctrl: per-cycle expectations go into a
// scoreboard queue when stimulus is driven and are checked at the
// following falling edge.
module tb_retire_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  ready_to_retire;
    logic        rob_rollback;
    logic [1:0]  head_wr_mem;
    logic [1:0]  head_halt;
    logic [9:0]  head_dest;
    logic [11:0] head_tag;
    logic [11:0] head_tag_old;
    logic [63:0] head_mem_addr;
    logic [63:0] head_mem_data;
    logic [3:0]  head_mem_size;
    logic        mem_grant;
    logic        mem_done;
    logic [1:0]  retire_en;
    logic [1:0]  free_en;
    logic [11:0] free_tag;
    logic [1:0]  arch_wr_en;
    logic [9:0]  arch_dest;
    logic [11:0] arch_tag;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [1:0]  mem_size;
    logic        halted;
    logic [31:0] retired_cnt;

    retire_ctrl dut (
        .clk(clk), .reset(reset),
        .ready_to_retire(ready_to_retire), .rob_rollback(rob_rollback),
        .head_wr_mem(head_wr_mem), .head_halt(head_halt),
        .head_dest(head_dest), .head_tag(head_tag), .head_tag_old(head_tag_old),
        .head_mem_addr(head_mem_addr), .head_mem_data(head_mem_data),
        .head_mem_size(head_mem_size),
        .mem_grant(mem_grant), .mem_done(mem_done),
        .retire_en(retire_en), .free_en(free_en), .free_tag(free_tag),
        .arch_wr_en(arch_wr_en), .arch_dest(arch_dest), .arch_tag(arch_tag),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_size(mem_size), .halted(halted), .retired_cnt(retired_cnt)
    );

    typedef struct {
        logic [1:0]  ret;
        logic [1:0]  fen;
        logic [11:0] ftag;
        logic [9:0]  adest;
        logic [11:0] atag;
        logic        req;
        logic [31:0] cnt;
        logic        hlt;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT should show during it.
    task automatic applyStimulus(input logic [1:0] rdy, input logic rb, input logic [1:0] wr,
                                 input logic [1:0] hl, input logic gnt, input logic dn,
                                 input logic [1:0] exp_ret, input logic exp_req,
                                 input logic exp_hlt);
        exp_t e;
        ready_to_retire = rdy;
        rob_rollback    = rb;
        head_wr_mem     = wr;
        head_halt       = hl;
        mem_grant       = gnt;
        mem_done        = dn;
        e.ret   = exp_ret;
        e.fen[0] = exp_ret[0] && (head_dest[4:0] != 5'd0);
        e.fen[1] = exp_ret[1] && (head_dest[9:5] != 5'd0);
        e.ftag  = head_tag_old;
        e.adest = head_dest;
        e.atag  = head_tag;
        e.req   = exp_req;
        e.cnt   = model_cnt;
        e.hlt   = exp_hlt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        model_cnt = model_cnt + 32'(exp_ret[0]) + 32'(exp_ret[1]);
    endtask

    // Scoreboard consumer: compare DUT outputs against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("retire_en", 64'(retire_en), 64'(e.ret));
            checkOutput("free_en", 64'(free_en), 64'(e.fen));
            checkOutput("arch_wr_en", 64'(arch_wr_en), 64'(e.fen));
            checkOutput("mem_req", 64'(mem_req), 64'(e.req));
            checkOutput("retired_cnt", 64'(retired_cnt), 64'(e.cnt));
            checkOutput("halted", 64'(halted), 64'(e.hlt));
            for (int w = 0; w < 2; w++) begin
                if (e.fen[w]) begin
                    checkOutput("free_tag", 64'(free_tag[w*6 +: 6]), 64'(e.ftag[w*6 +: 6]));
                    checkOutput("arch_dest", 64'(arch_dest[w*5 +: 5]), 64'(e.adest[w*5 +: 5]));
                    checkOutput("arch_tag", 64'(arch_tag[w*6 +: 6]), 64'(e.atag[w*6 +: 6]));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        ready_to_retire = 2'b00;
        rob_rollback = 1'b0;
        head_wr_mem = 2'b00;
        head_halt = 2'b00;
        head_dest = {5'd4, 5'd3};
        head_tag = {6'd21, 6'd20};
        head_tag_old = {6'd11, 6'd10};
        head_mem_addr = '0;
        head_mem_data = '0;
        head_mem_size = '0;
        mem_grant = 1'b0;
        mem_done = 1'b0;

        #3;
        checkOutput("rst_retired_cnt", 64'(retired_cnt), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] dual ALU retire");
        applyStimulus(2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        checkOutput("cnt_after_dual", 64'(retired_cnt), 64'd2);

        $display("[TB] store with separate grant and done");
        head_dest = {5'd7, 5'd0};
        head_mem_addr = {32'h0, 32'h0000_1000};
        head_mem_data = {32'h0, 32'h0000_DEAD};
        head_mem_size = {2'b00, 2'b10};
        applyStimulus(2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        checkOutput("st_mem_addr", 64'(mem_addr), 64'h1000);
        checkOutput("st_mem_data", 64'(mem_data), 64'hDEAD);
        checkOutput("st_mem_size", 64'(mem_size), 64'd2);
        applyStimulus(2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b11, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        head_dest = {5'd4, 5'd3};
        applyStimulus(2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);

        $display("[TB] store with grant and done together");
        head_dest = {5'd4, 5'd0};
        head_mem_addr = {32'h0, 32'h0000_2040};
        applyStimulus(2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        checkOutput("st2_mem_addr", 64'(mem_addr), 64'h2040);
        applyStimulus(2'b01, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        head_dest = {5'd4, 5'd3};

        $display("[TB] rollback drain");
        applyStimulus(2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);

        $display("[TB] halt");
        applyStimulus(2'b11, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
        end

        ready_to_retire = 2'b11;
        head_wr_mem = 2'b00;
        rob_rollback = 1'b0;
        reset = 1'b1;
        #2;
        checkOutput("hrst_halted", 64'(halted), 64'd0);
        checkOutput("hrst_retired_cnt", 64'(retired_cnt), 64'd0);
        checkOutput("hrst_idle_retire", 64'(retire_en), 64'd3);
        ready_to_retire = 2'b00;
        reset = 1'b0;
        model_cnt = 0;
        @(posedge clk);
        #1;

        $display("[TB] reset during ST_WAIT");
        applyStimulus(2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        ready_to_retire = 2'b11;
        head_wr_mem = 2'b00;
        mem_grant = 1'b0;
        #2;
        checkOutput("wait_no_retire", 64'(retire_en), 64'd0);
        checkOutput("wait_cnt", 64'(retired_cnt), 64'd2);
        reset = 1'b1;
        #1;
        checkOutput("wrst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("wrst_idle_retire", 64'(retire_en), 64'd3);
        checkOutput("wrst_halted", 64'(halted), 64'd0);
        checkOutput("wrst_retired_cnt", 64'(retired_cnt), 64'd0);
        checkOutput("wrst_mem_addr", 64'(mem_addr), 64'd0);
        ready_to_retire = 2'b00;
        reset = 1'b0;
        model_cnt = 0;
        @(posedge clk);
        #1;

        $display("[TB] reset during ST_REQ");
        applyStimulus(2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        #2;
        checkOutput("req_high", 64'(mem_req), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("rrst_mem_req", 64'(mem_req), 64'd0);
        ready_to_retire = 2'b00;
        head_wr_mem = 2'b00;
        reset = 1'b0;
        @(posedge clk);
        #1;

        checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
